// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes and FSM states.
// Imported by lsu_data_align and load_store_unit.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_MERGE = 3'd2,
    ST_WRITE = 3'd3,
    ST_RESP  = 3'd4
  } lsu_state_e;

  // Encoding 3 is not a distinct size; the unit handles it exactly like a word.
  function automatic logic is_word(input logic [1:0] size);
    return size[1];
  endfunction

endpackage

// File: rtl/lsu_data_align.sv
// Combinational data path of the load/store unit: load sign/zero extension and
// sub-word store merge into the word read back from memory. Requires byte_W >= 2.
module lsu_data_align
  import lsu_pkg::*;
#(
  parameter int byte_W = 4
) (
  input  logic [8*byte_W-1:0] load_rdata,
  input  logic [1:0]          load_size,
  input  logic                load_signed,
  output logic [8*byte_W-1:0] load_data,
  input  logic [8*byte_W-1:0] store_old,
  input  logic [8*byte_W-1:0] store_new,
  input  logic [1:0]          store_size,
  output logic [8*byte_W-1:0] store_merged
);

  localparam int W = 8 * byte_W;

  logic byte_sign;
  logic half_sign;

  assign byte_sign = load_signed & load_rdata[7];
  assign half_sign = load_signed & load_rdata[15];

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    load_data = load_rdata;
    if (!is_word(load_size)) begin
      if (load_size == SZ_BYTE) begin
        load_data = {{(W - 8){byte_sign}}, load_rdata[7:0]};
      end else begin
        load_data = {{(W - 16){half_sign}}, load_rdata[15:0]};
      end
    end
  end

  always_comb begin
    store_merged = store_new;
    if (!is_word(store_size)) begin
      if (store_size == SZ_BYTE) begin
        store_merged = {store_old[W-1:8], store_new[7:0]};
      end else begin
        store_merged = {store_old[W-1:16], store_new[15:0]};
      end
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store initiator for data_memory: one request in flight, read-modify-write
// for sub-word stores. Optional misalignment rejection under `ALIGN_CHECK_EN.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int byte_W = 4,
  parameter int Addr_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                inp_req_valid,
  output logic                out_req_ready,
  input  logic                inp_req_write,
  input  logic [1:0]          inp_req_size,
  input  logic                inp_req_signed,
  input  logic [Addr_W-1:0]   inp_req_address,
  input  logic [8*byte_W-1:0] inp_req_wdata,
  output logic                out_resp_valid,
  output logic [8*byte_W-1:0] out_resp_rdata,
  output logic                out_resp_error,
  output logic [Addr_W-1:0]   out_mem_address,
  output logic [8*byte_W-1:0] out_mem_wdata,
  output logic                out_mem_write_enable,
  input  logic [8*byte_W-1:0] inp_mem_rdata
);

  localparam int W = 8 * byte_W;

  lsu_state_e        state;
  logic              write_q;
  logic [1:0]        size_q;
  logic              signed_q;
  logic [Addr_W-1:0] addr_q;
  logic [W-1:0]      data_q;
  logic [W-1:0]      rdata_q;
  logic [W-1:0]      load_data;
  logic [W-1:0]      store_merged;
  logic              misaligned;

`ifdef ALIGN_CHECK_EN
  localparam int OFS_W = (byte_W > 1) ? $clog2(byte_W) : 1;
  logic err_q;

  assign misaligned = (inp_req_size == SZ_HALF && inp_req_address[0]) ||
                      (is_word(inp_req_size) && inp_req_address[OFS_W-1:0] != '0);
`else
  assign misaligned = 1'b0;
`endif

  lsu_data_align #(
    .byte_W (byte_W)
  ) u_align (
    .load_rdata   (inp_mem_rdata),
    .load_size    (size_q),
    .load_signed  (signed_q),
    .load_data    (load_data),
    .store_old    (inp_mem_rdata),
    .store_new    (data_q),
    .store_size   (size_q),
    .store_merged (store_merged)
  );

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      write_q  <= 1'b0;
      size_q   <= SZ_BYTE;
      signed_q <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      rdata_q  <= '0;
`ifdef ALIGN_CHECK_EN
      err_q    <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (inp_req_valid) begin
            write_q  <= inp_req_write;
            size_q   <= inp_req_size;
            signed_q <= inp_req_signed;
            addr_q   <= inp_req_address;
            data_q   <= inp_req_wdata;
            rdata_q  <= '0;
`ifdef ALIGN_CHECK_EN
            err_q    <= misaligned;
`endif
            if (misaligned) begin
              state <= ST_RESP;
            end else if (!inp_req_write) begin
              state <= ST_LOAD;
            end else if (is_word(inp_req_size)) begin
              state <= ST_WRITE;
            end else begin
              state <= ST_MERGE;
            end
          end
        end
        ST_LOAD: begin
          rdata_q <= load_data;
          state   <= ST_RESP;
        end
        ST_MERGE: begin
          data_q <= store_merged;
          state  <= ST_WRITE;
        end
        ST_WRITE: state <= ST_RESP;
        ST_RESP:  state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // Outputs decode straight from the state register, so an asynchronous reset
  // clears them (and withdraws a pending write) in the same cycle.
  assign out_req_ready        = (state == ST_IDLE) && rst_n;
  assign out_mem_write_enable = (state == ST_WRITE);
  assign out_mem_wdata        = (state == ST_WRITE) ? data_q : '0;
  assign out_mem_address      = (state inside {ST_LOAD, ST_MERGE, ST_WRITE}) ? addr_q : '0;
  assign out_resp_valid       = (state == ST_RESP);
  assign out_resp_rdata       = (state == ST_RESP && !write_q) ? rdata_q : '0;

`ifdef ALIGN_CHECK_EN
  assign out_resp_error = (state == ST_RESP) && err_q;
`else
  assign out_resp_error = 1'b0;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural byte-addressed data_memory
// behind it; expectations cover both ALIGN_CHECK_EN builds.
module tb_load_store_unit;
  import lsu_pkg::*;

  localparam int BW = 4;
  localparam int AW = 8;
  localparam int W  = 8 * BW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [1:0]    req_size = 2'd0;
  logic          req_signed = 1'b0;
  logic [AW-1:0] req_address = '0;
  logic [W-1:0]  req_wdata = '0;
  logic          resp_valid;
  logic [W-1:0]  resp_rdata;
  logic          resp_error;
  logic [AW-1:0] mem_address;
  logic [W-1:0]  mem_wdata;
  logic          mem_we;
  logic [W-1:0]  mem_rdata;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  load_store_unit #(.byte_W(BW), .Addr_W(AW)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .inp_req_valid        (req_valid),
    .out_req_ready        (req_ready),
    .inp_req_write        (req_write),
    .inp_req_size         (req_size),
    .inp_req_signed       (req_signed),
    .inp_req_address      (req_address),
    .inp_req_wdata        (req_wdata),
    .out_resp_valid       (resp_valid),
    .out_resp_rdata       (resp_rdata),
    .out_resp_error       (resp_error),
    .out_mem_address      (mem_address),
    .out_mem_wdata        (mem_wdata),
    .out_mem_write_enable (mem_we),
    .inp_mem_rdata        (mem_rdata)
  );

  // data_memory model: combinational little-endian read, full-word write on posedge.
  logic [7:0] mem [256];
  bit mem_loaded = 1'b0;

  always_comb begin
    mem_rdata = '0;
    for (int i = 0; i < BW; i++) mem_rdata[8*i +: 8] = mem[AW'(mem_address + AW'(i))];
  end

  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i);
      mem_loaded <= 1'b1;
    end else if (mem_we) begin
      for (int i = 0; i < BW; i++) mem[AW'(mem_address + AW'(i))] <= mem_wdata[8*i +: 8];
    end
  end

  function automatic logic [31:0] mem_word(input logic [7:0] a);
    return {mem[a + 8'd3], mem[a + 8'd2], mem[a + 8'd1], mem[a]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One request: waits (bounded) for ready, counts edges from accept to resp_valid
  // and write-enable cycles seen on the way, then checks all of it.
  task automatic txn(input string tag, input logic wr, input logic [1:0] sz, input logic sg,
                     input logic [7:0] a, input logic [31:0] wd, input int exp_lat,
                     input logic [31:0] exp_rd, input int exp_we, input logic exp_err);
    int wait_cyc = 0;
    int lat = 0;
    int we_cyc = 0;
    req_valid = 1'b1; req_write = wr; req_size = sz; req_signed = sg;
    req_address = a; req_wdata = wd;
    while (!req_ready && wait_cyc < 10) begin
      step();
      wait_cyc++;
    end
    chk({tag, "_ready"}, 32'(req_ready), 32'd1);
    step();
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 10) begin
      if (mem_we) we_cyc++;
      step();
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_rdata"}, resp_rdata, exp_rd);
    chk({tag, "_we_cycles"}, 32'(we_cyc), 32'(exp_we));
    chk({tag, "_error"}, 32'(resp_error), 32'(exp_err));
    step();
  endtask

  initial begin
    int accepts;
    int nresp;
    int resp_at [2];
    logic acc;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_mem_address", 32'(mem_address), 32'd0);
    rst_n = 1'b1;
    step();
    chk("rel_ready", 32'(req_ready), 32'd1);

    // Word store, then loads of several sizes over it
    txn("st_word", 1'b1, SZ_WORD, 1'b0, 8'h10, 32'hDEADBEEF, 2, 32'h0, 1, 1'b0);
    chk("mem_after_st_word", mem_word(8'h10), 32'hDEADBEEF);
    txn("ld_sword", 1'b0, SZ_WORD, 1'b1, 8'h10, 32'h0, 2, 32'hDEADBEEF, 0, 1'b0);
    txn("ld_sbyte", 1'b0, SZ_BYTE, 1'b1, 8'h10, 32'h0, 2, 32'hFFFFFFEF, 0, 1'b0);
    txn("ld_uhalf", 1'b0, SZ_HALF, 1'b0, 8'h12, 32'h0, 2, 32'h0000DEAD, 0, 1'b0);
    txn("ld_shalf", 1'b0, SZ_HALF, 1'b1, 8'h12, 32'h0, 2, 32'hFFFFDEAD, 0, 1'b0);
    txn("ld_ubyte", 1'b0, SZ_BYTE, 1'b0, 8'h13, 32'h0, 2, 32'h000000DE, 0, 1'b0);
    txn("ld_size3", 1'b0, 2'd3, 1'b0, 8'h10, 32'h0, 2, 32'hDEADBEEF, 0, 1'b0);

    // Byte store: read-modify-write, only the low wdata byte lands
    txn("st_byte", 1'b1, SZ_BYTE, 1'b0, 8'h11, 32'hAABBCC55, 3, 32'h0, 1, 1'b0);
    chk("mem_after_st_byte", mem_word(8'h10), 32'hDEAD55EF);
    txn("ld_after_st_byte", 1'b0, SZ_WORD, 1'b0, 8'h10, 32'h0, 2, 32'hDEAD55EF, 0, 1'b0);

    // Misaligned accesses
`ifdef ALIGN_CHECK_EN
    txn("ld_word_0x11", 1'b0, SZ_WORD, 1'b0, 8'h11, 32'h0, 1, 32'h0, 0, 1'b1);
    txn("ld_half_0x11", 1'b0, SZ_HALF, 1'b0, 8'h11, 32'h0, 1, 32'h0, 0, 1'b1);
`else
    txn("ld_word_0x11", 1'b0, SZ_WORD, 1'b0, 8'h11, 32'h0, 2, 32'h14DEAD55, 0, 1'b0);
    txn("ld_half_0x11", 1'b0, SZ_HALF, 1'b0, 8'h11, 32'h0, 2, 32'h0000AD55, 0, 1'b0);
`endif

    // Half store at 0x12: merge into the word read from 0x12..0x15
    txn("st_half", 1'b1, SZ_HALF, 1'b0, 8'h12, 32'hFFFF7788, 3, 32'h0, 1, 1'b0);
    chk("mem_hi_after_st_half", mem_word(8'h12), 32'h15147788);
    txn("ld_after_st_half", 1'b0, SZ_WORD, 1'b0, 8'h10, 32'h0, 2, 32'h778855EF, 0, 1'b0);

    // valid held high across two loads: exactly two accepts, responses at samples 2 and 5
    req_valid = 1'b1; req_write = 1'b0; req_size = SZ_WORD; req_signed = 1'b0;
    req_address = 8'h10; req_wdata = '0;
    accepts = 0; nresp = 0; resp_at[0] = -1; resp_at[1] = -1;
    for (int s = 0; s < 8; s++) begin
      if (resp_valid) begin
        if (nresp < 2) resp_at[nresp] = s;
        nresp++;
      end
      acc = req_valid && req_ready;
      if (acc) accepts++;
      step();
      if (acc && accepts == 2) req_valid = 1'b0;
    end
    chk("b2b_accepts", 32'(accepts), 32'd2);
    chk("b2b_responses", 32'(nresp), 32'd2);
    chk("b2b_first_resp", 32'(resp_at[0]), 32'd2);
    chk("b2b_second_resp", 32'(resp_at[1]), 32'd5);

    // Reset during WRITE: the write is withdrawn before the edge
    req_valid = 1'b1; req_write = 1'b1; req_size = SZ_WORD; req_address = 8'h20;
    req_wdata = 32'hCAFEF00D;
    step();
    req_valid = 1'b0;
    chk("wr_state_we", 32'(mem_we), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_in_write_we", 32'(mem_we), 32'd0);
    chk("rst_in_write_wdata", mem_wdata, 32'h0);
    step();
    chk("rst_in_write_mem", mem_word(8'h20), 32'h23222120);
    rst_n = 1'b1;
    step();
    chk("rst_in_write_ready", 32'(req_ready), 32'd1);

    // Reset mid-LOAD: every output low in the same cycle
    req_valid = 1'b1; req_write = 1'b0; req_size = SZ_WORD; req_address = 8'h10;
    step();
    req_valid = 1'b0;
    chk("load_state_address", 32'(mem_address), 32'h10);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_in_load_ready", 32'(req_ready), 32'd0);
    chk("rst_in_load_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_in_load_rdata", resp_rdata, 32'h0);
    chk("rst_in_load_error", 32'(resp_error), 32'd0);
    chk("rst_in_load_address", 32'(mem_address), 32'h0);
    chk("rst_in_load_we", 32'(mem_we), 32'd0);
    #1 rst_n = 1'b1;
    step();
    chk("rst_in_load_ready_after", 32'(req_ready), 32'd1);
    txn("ld_after_reset", 1'b0, SZ_WORD, 1'b0, 8'h10, 32'h0, 2, 32'h778855EF, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
